sub_serial: RTL

Bit-serial subtractor, the inverse-operation companion to the team's bit-serial adder. It latches two WIDTH-bit operands on a start request and computes a − b one bit per cycle, LSB first, using a single ripple borrow. It presents the difference and the final borrow with a done indication. It sits beside the serial adder in the arithmetic datapath, sharing the same enable-driven IDLE/compute/DONE control style.

---
 rtl/sub_serial.sv | 110 +++++++++++
 1 files changed

// File: rtl/sub_serial.sv
// ============================================================================
// Module   : sub_serial
// Brief    : Bit-serial subtractor, a - b LSB first with a single ripple borrow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_out;
    logic              r_borrow;
    logic              r_borrow_out;
    logic [c_CW-1:0]   r_count;

    logic              w_diff;
    logic              w_borrow_nxt;
    logic              w_last;

    assign w_diff       = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
    assign w_last       = (r_count == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Unused encoding 3 falls into the default arm and recovers to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en)     w_state_nxt = S_SUB;
            S_SUB:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (!en)    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_out        <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_out    <= '0;
                        r_borrow <= 1'b0;
                        r_count  <= '0;
                    end
                end
                S_SUB: begin
                    // Difference bits enter at the MSB so bit i lands at out[i].
                    r_out    <= {w_diff, r_out[WIDTH-1:1]};
                    r_borrow <= w_borrow_nxt;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_count  <= r_count + c_CW'(1);
                    if (w_last) begin
                        r_borrow_out <= w_borrow_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out        = r_out;
    assign borrow_out = r_borrow_out;
    assign busy       = (r_state == S_SUB);
    assign done       = (r_state == S_DONE);

endmodule

`default_nettype wire
